// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file access controller.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 8;

    // Controller phase: clearing the file, or serving the pipeline.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Identity of a write-port requester.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/regfile_port_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter for the shared register-file write port.
// A lone requester wins at once; on a tie the requester that did not win
// the previous grant goes first.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_alu,
    input  logic req_mem,
    input  logic advance,
    output logic gnt_alu,
    output logic gnt_mem
);

    req_id_e last_winner;

    // Combinational grant: ties go to whoever did not win last time.
    always_comb begin
        gnt_alu = req_alu & (~req_mem | (last_winner == REQ_MEM));
        gnt_mem = req_mem & (~req_alu | (last_winner == REQ_ALU));
    end

    // Record the winner whenever a grant is consumed so the next tie flips.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner <= REQ_MEM;
        end else if (advance) begin
            last_winner <= gnt_alu ? REQ_ALU : REQ_MEM;
        end
    end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Register-file access controller: clears the file after reset, arbitrates
// the single write port between ALU writeback and memory loads, and issues
// operand reads with a one-cycle stall on read-after-write collisions.
module regfile_port_ctrl #(
    parameter int                 ADDR_W     = regfile_pkg::ADDR_W,
    parameter int                 DATA_W     = regfile_pkg::DATA_W,
    parameter bit                 INIT_EN    = 1'b1,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              alu_wr_req,
    input  logic [ADDR_W-1:0] alu_wr_addr,
    input  logic [DATA_W-1:0] alu_wr_data,
    output logic              alu_wr_gnt,
    input  logic              mem_wr_req,
    input  logic [ADDR_W-1:0] mem_wr_addr,
    input  logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_a_addr,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic              rf_en_rd,
    output logic [ADDR_W-1:0] rf_ra_addr,
    output logic [ADDR_W-1:0] rf_rd_addr,
    output logic              rf_en_wd,
    output logic [ADDR_W-1:0] rf_wd_addr,
    output logic [DATA_W-1:0] rf_wd
);

    import regfile_pkg::*;

    localparam logic              ST_INIT   = INIT;
    localparam logic              ST_RUN    = RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic              state;
    logic [ADDR_W-1:0] init_cnt;
    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_data;
    logic              grant_ok;
    logic              wr_any;
    logic              collide;

    assign ready = (state == ST_RUN);

    // No grant is handed out while reset is asserted, so requesters keep
    // holding and are served once the clear sequence finishes.
    assign grant_ok = ready & ~rst;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_alu (alu_wr_req & grant_ok),
        .req_mem (mem_wr_req & grant_ok),
        .advance (wr_any),
        .gnt_alu (alu_wr_gnt),
        .gnt_mem (mem_wr_gnt)
    );

    assign wr_any = alu_wr_gnt | mem_wr_gnt;

    // A read may not see an address whose new value is still sitting in S1.
    assign collide    = s1_valid & ((rd_a_addr == s1_addr) | (rd_b_addr == s1_addr));
    assign rd_gnt     = rd_req & grant_ok & ~collide;
    assign rf_en_rd   = rd_gnt;
    assign rf_ra_addr = rd_a_addr;
    assign rf_rd_addr = rd_b_addr;

    // Write port source: the clear walker during INIT, otherwise stage S1.
    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        if (state == ST_INIT) begin
            rf_en_wd   = 1'b1;
            rf_wd_addr = init_cnt;
            rf_wd      = INIT_VALUE;
        end else begin
            // A pending S1 write is dropped if reset arrives in its cycle.
            rf_en_wd   = s1_valid & ~rst;
            rf_wd_addr = s1_addr;
            rf_wd      = s1_data;
        end
    end

    // Phase control: walk every address once, then serve the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT_EN ? ST_INIT : ST_RUN;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == LAST_ADDR) begin
                state <= ST_RUN;
            end
        end
    end

    // Control flags of the write stage and the read-valid pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            s1_valid <= wr_any;
            rd_valid <= rd_gnt;
        end
    end

    // Write stage payload; only meaningful while s1_valid is set.
    // NOTE: datapath registers are left out of reset; the valid flag alone
    // qualifies them.
    always_ff @(posedge clk) begin
        if (wr_any) begin
            s1_addr <= alu_wr_gnt ? alu_wr_addr : mem_wr_addr;
            s1_data <= alu_wr_gnt ? alu_wr_data : mem_wr_data;
        end
    end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Randomized self-checking bench for regfile_port_ctrl. A small register-file
// model hangs off the rf_* port; an architectural register array tracks what
// every read should return.
module tb_regfile_port_ctrl;

    localparam int             AW       = 5;
    localparam int             DW       = 8;
    localparam int             NREG     = 32;
    localparam logic [DW-1:0]  INIT_VAL = 8'h00;
    localparam int             CYCLES   = 4000;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready;
    logic          alu_wr_req, mem_wr_req, rd_req;
    logic [AW-1:0] alu_wr_addr, mem_wr_addr, rd_a_addr, rd_b_addr;
    logic [DW-1:0] alu_wr_data, mem_wr_data;
    logic          alu_wr_gnt, mem_wr_gnt, rd_gnt, rd_valid;
    logic          rf_en_rd, rf_en_wd;
    logic [AW-1:0] rf_ra_addr, rf_rd_addr, rf_wd_addr;
    logic [DW-1:0] rf_wd;

    regfile_port_ctrl #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .INIT_EN    (1'b1),
        .INIT_VALUE (INIT_VAL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .alu_wr_req  (alu_wr_req),
        .alu_wr_addr (alu_wr_addr),
        .alu_wr_data (alu_wr_data),
        .alu_wr_gnt  (alu_wr_gnt),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_gnt  (mem_wr_gnt),
        .rd_req      (rd_req),
        .rd_a_addr   (rd_a_addr),
        .rd_b_addr   (rd_b_addr),
        .rd_gnt      (rd_gnt),
        .rd_valid    (rd_valid),
        .rf_en_rd    (rf_en_rd),
        .rf_ra_addr  (rf_ra_addr),
        .rf_rd_addr  (rf_rd_addr),
        .rf_en_wd    (rf_en_wd),
        .rf_wd_addr  (rf_wd_addr),
        .rf_wd       (rf_wd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Register file attached to the controller: junk contents at start,
    // synchronous read on rf_en_rd, write on rf_en_wd.
    logic [DW-1:0] rf_mem [NREG];
    logic [DW-1:0] ra_q, rb_q;
    bit            rf_scrambled = 1'b0;

    always @(posedge clk) begin
        if (!rf_scrambled) begin
            for (int i = 0; i < NREG; i++) rf_mem[i] <= DW'($urandom_range(1, 255));
            rf_scrambled <= 1'b1;
        end
        if (rf_en_rd === 1'b1) begin
            ra_q <= rf_mem[rf_ra_addr];
            rb_q <= rf_mem[rf_rd_addr];
        end
        if (rf_en_wd === 1'b1) rf_mem[rf_wd_addr] <= rf_wd;
    end

    // Reference model state.
    logic [DW-1:0] arch [NREG];     // value each register must hold
    int            init_pos;        // clear cycles done since reset
    bit            pend_v;          // write granted last cycle, due on the port now
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_d;
    bit            last_mem;        // memory path won the previous write grant
    bit            exp_rdv;
    logic [DW-1:0] exp_ra, exp_rb;
    bit            ea, em, er, in_init, clash;
    bit            nx_rdv;
    logic [DW-1:0] nx_ra, nx_rb;
    bit            forced_done;

    task automatic model_reset();
        init_pos = 0;
        pend_v   = 1'b0;
        last_mem = 1'b1;
        exp_rdv  = 1'b0;
        for (int i = 0; i < NREG; i++) arch[i] = INIT_VAL;
    endtask

    function automatic logic [AW-1:0] pick_addr();
        // Bias towards a few registers so collisions happen often.
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        rst = 1'b1;
        alu_wr_req = 1'b0; alu_wr_addr = '0; alu_wr_data = '0;
        mem_wr_req = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
        rd_req = 1'b0; rd_a_addr = '0; rd_b_addr = '0;
        forced_done = 1'b0;
        nx_rdv = 1'b0; nx_ra = '0; nx_rb = '0;
        model_reset();

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            ea = 1'b0; em = 1'b0; er = 1'b0;
            if (rst) begin
                // Whatever was staged must not reach the file in a reset cycle.
                check("rst_no_staged_write",
                      32'((rf_en_wd === 1'b1) && (rf_wd !== INIT_VAL)), 32'd0);
            end else begin
                in_init = (init_pos < NREG);
                check("ready", 32'(ready), 32'(!in_init));
                if (in_init) begin
                    check("init_wr_en", 32'(rf_en_wd), 32'd1);
                    check("init_wr_addr", 32'(rf_wd_addr), 32'(init_pos));
                    check("init_wr_data", 32'(rf_wd), 32'(INIT_VAL));
                end else begin
                    if (alu_wr_req && mem_wr_req) begin
                        ea = last_mem;
                        em = !last_mem;
                    end else begin
                        ea = alu_wr_req;
                        em = mem_wr_req;
                    end
                    clash = pend_v && (rd_a_addr == pend_a || rd_b_addr == pend_a);
                    er    = rd_req && !clash;
                    check("wr_en", 32'(rf_en_wd), 32'(pend_v));
                    if (pend_v) begin
                        check("wr_addr", 32'(rf_wd_addr), 32'(pend_a));
                        check("wr_data", 32'(rf_wd), 32'(pend_d));
                    end
                end
                check("grants", 32'({alu_wr_gnt, mem_wr_gnt, rd_gnt, rf_en_rd}),
                      32'({ea, em, er, er}));
                check("rd_addr_pass", 32'({rf_ra_addr, rf_rd_addr}), 32'({rd_a_addr, rd_b_addr}));
                check("rd_valid", 32'(rd_valid), 32'(exp_rdv));
                if (exp_rdv) begin
                    check("ra_data", 32'(ra_q), 32'(exp_ra));
                    check("rb_data", 32'(rb_q), 32'(exp_rb));
                end
                // A read sees the file before any write granted this cycle.
                nx_rdv = er;
                nx_ra  = arch[rd_a_addr];
                nx_rb  = arch[rd_b_addr];
            end

            @(posedge clk);
            #1;
            if (rst) begin
                model_reset();
                rst = 1'b0;
            end else begin
                if (init_pos < NREG) init_pos++;
                exp_rdv = nx_rdv;
                exp_ra  = nx_ra;
                exp_rb  = nx_rb;
                pend_v  = ea || em;
                if (ea) begin
                    pend_a = alu_wr_addr; pend_d = alu_wr_data;
                    arch[alu_wr_addr] = alu_wr_data;
                    last_mem = 1'b0;
                end else if (em) begin
                    pend_a = mem_wr_addr; pend_d = mem_wr_data;
                    arch[mem_wr_addr] = mem_wr_data;
                    last_mem = 1'b1;
                end
            end

            // New requests replace granted ones; ungranted ones stay put.
            if (!alu_wr_req || ea) begin
                alu_wr_req  = ($urandom_range(0, 99) < 55);
                alu_wr_addr = pick_addr();
                alu_wr_data = DW'($urandom);
            end
            if (!mem_wr_req || em) begin
                mem_wr_req  = ($urandom_range(0, 99) < 55);
                mem_wr_addr = pick_addr();
                mem_wr_data = DW'($urandom);
            end
            if (!rd_req || er) begin
                rd_req    = ($urandom_range(0, 99) < 60);
                rd_a_addr = pick_addr();
                rd_b_addr = pick_addr();
            end

            // Reset the cycle after a memory grant, then read that register.
            if (cyc < 2) begin
                rst = 1'b1;
            end else if (!forced_done && cyc > 300 && em) begin
                rst         = 1'b1;
                forced_done = 1'b1;
                rd_req      = 1'b1;
                rd_a_addr   = pend_a;
            end else if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
            end
        end

        check("forced_reset_after_mem_grant", 32'(forced_done), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
